// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// RAM handshake states, data word, and RAM arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between fetch and data requesters.
// Data has priority; a starvation counter forces fetch through.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t state, nxt;
  logic       g_wen;
  word_t      g_addr;
  word_t      g_store;
  logic [2:0] starve_cnt;
  logic       dreq;
  logic       force_i;
  logic       done;
  logic       live;

  assign dreq    = dREN | dWEN;
  assign force_i = iREN && (starve_cnt == 3'(STARVE_MAX));
  assign done    = (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nxt;
  end

  // A dropped request is a pipeline flush: release the grant.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (dreq && !force_i) nxt = DGNT;
        else if (iREN)        nxt = IGNT;
        else                  nxt = IDLE;
      end
      IGNT: if (!iREN || done) nxt = IDLE;
      DGNT: if (!dreq || done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      g_wen   <= 1'b0;
      g_addr  <= '0;
      g_store <= '0;
    end else if (state == IDLE) begin
      if (nxt == DGNT) begin
        g_wen   <= dWEN;
        g_addr  <= daddr;
        g_store <= dstore;
      end else if (nxt == IGNT) begin
        g_wen   <= 1'b0;
        g_addr  <= iaddr;
        g_store <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (nxt == IGNT || !iREN)
        starve_cnt <= '0;
      else if (nxt == DGNT && starve_cnt != 3'(STARVE_MAX))
        starve_cnt <= starve_cnt + 3'd1;
    end
  end

  always_comb begin
    live = ((state == IGNT) && iREN) ||
           ((state == DGNT) && dreq);
    ramREN   = live && !g_wen;
    ramWEN   = live && g_wen;
    ramaddr  = g_addr;
    ramstore = g_store;
    iwait    = iREN && !((state == IGNT) && done);
    dwait    = dreq && !((state == DGNT) && done);
    iload    = ramload;
    dload    = ramload;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed scenarios then
// randomized concurrent fetch/data traffic against a RAM model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int STARVE = 4;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  ram_arbiter #(.STARVE_MAX(STARVE)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    logic  wr;
    word_t a;
    word_t d;
  } dexp_t;

  int cmps = 0;
  int fails = 0;

  word_t     pmem[word_t];
  word_t     rmem[word_t];
  word_t     iqa[$];
  word_t     iqd[$];
  dexp_t     dq[$];
  ramstate_t rs_q[$];
  bit        order_q[$];
  bit        rnd = 0;
  int        ren_cnt = 0;
  int        icomp = 0;
  int        dcomp = 0;
  int        srun = 0;
  word_t     last_addr = '0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic word_t dflt(word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic word_t rrd(word_t a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  function automatic word_t prd(word_t a);
    return pmem.exists(a) ? pmem[a] : dflt(a);
  endfunction

  task automatic chk(string nm, word_t act, word_t exp);
    cmps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic miss(string nm);
    cmps++;
    fails++;
    $display("FAIL %s: got none expected event", nm);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_done(bit d);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((d ? dwait : iwait) && n < 300);
    if (d ? dwait : iwait) miss(d ? "dwait_timeout" : "iwait_timeout");
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(word_t a);
    iqa.push_back(a);
    iqd.push_back(rrd(a));
    iaddr = a;
    iREN  = 1'b1;
    wait_done(1'b0);
    iREN  = 1'b0;
  endtask

  task automatic data_op(bit wr, word_t a, word_t d, bit both);
    dexp_t e;
    e.wr = wr;
    e.a  = a;
    if (wr) begin
      rmem[a] = d;
      e.d = d;
    end else begin
      e.d = rrd(a);
    end
    dq.push_back(e);
    daddr  = a;
    dstore = wr ? d : word_t'($urandom);
    dWEN   = wr;
    dREN   = !wr || both;
    wait_done(1'b1);
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  // RAM model: scripted or random latency, ERROR retries.
  always @(posedge CLK) begin
    int r;
    #2;
    if (ramREN || ramWEN) begin
      if (rs_q.size() > 0) begin
        ramstate = rs_q.pop_front();
      end else if (rnd) begin
        r = $urandom_range(0, 9);
        ramstate = (r < 2) ? ERROR : (r < 5) ? BUSY : ACCESS;
      end else begin
        ramstate = ACCESS;
      end
    end else begin
      ramstate = FREE;
    end
    ramload = prd(ramaddr);
  end

  // Monitor: pops expectations whenever a requester completes.
  always @(negedge CLK) begin
    word_t a;
    word_t d;
    dexp_t e;
    if (nRST) begin
      if (ramREN || ramWEN) begin
        ren_cnt += int'(ramREN);
        last_addr = ramaddr;
        chk("strobe_excl", word_t'(ramREN & ramWEN), 0);
      end
      if (iREN && !iwait) begin
        if (iqa.size() == 0) begin
          miss("fetch_unexpected");
        end else begin
          a = iqa.pop_front();
          d = iqd.pop_front();
          chk("fetch_addr", ramaddr, a);
          chk("iload", iload, d);
        end
        order_q.push_back(1'b0);
        icomp++;
        srun = 0;
      end else if (!iREN) begin
        srun = 0;
      end
      if ((dREN || dWEN) && !dwait) begin
        if (dq.size() == 0) begin
          miss("data_unexpected");
        end else begin
          e = dq.pop_front();
          chk("data_addr", ramaddr, e.a);
          if (e.wr) begin
            chk("ram_wen", word_t'(ramWEN), 1);
            chk("ramstore", ramstore, e.d);
          end else begin
            chk("dload", dload, e.d);
          end
        end
        order_q.push_back(1'b1);
        dcomp++;
        if (iREN) begin
          srun++;
          chk("starve_bound", word_t'(srun <= STARVE + 1), 1);
        end
      end
      if (ramWEN && ramstate == ACCESS) pmem[ramaddr] = ramstore;
    end
  end

  initial begin
    int b0;
    int b1;
    logic [5:0] pat;
    nRST = 1'b0;
    iREN = 1'b1;
    iaddr = '0;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    ramstate = FREE;
    ramload = '0;
    pmem[32'h40] = 32'hDEAD_BEEF;
    rmem[32'h40] = 32'hDEAD_BEEF;

    @(negedge CLK);
    chk("rst_ramREN", word_t'(ramREN), 0);
    chk("rst_ramWEN", word_t'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_iwait", word_t'(iwait), 1);
    chk("rst_dwait", word_t'(dwait), 0);
    iREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    step(2);

    // Single fetch with two BUSY cycles
    b0 = ren_cnt;
    b1 = icomp;
    rs_q.push_back(BUSY);
    rs_q.push_back(BUSY);
    fetch(32'h40);
    chk("f1_ren_cycles", word_t'(ren_cnt - b0), 3);
    chk("f1_completions", word_t'(icomp - b1), 1);
    chk("f1_addr", last_addr, 32'h40);
    step(2);

    // Simultaneous fetch and data write: data first
    b0 = order_q.size();
    fork
      fetch(32'h44);
      data_op(1'b1, 32'h100, 32'h1234, 1'b0);
    join
    chk("sim_count", word_t'(order_q.size() - b0), 2);
    if (order_q.size() >= b0 + 2) begin
      chk("sim_first_data", word_t'(order_q[b0]), 1);
      chk("sim_then_fetch", word_t'(order_q[b0 + 1]), 0);
    end
    step(2);

    // Starvation: fetch forced after STARVE data grants
    b0 = order_q.size();
    fork
      fetch(32'h48);
      begin
        for (int k = 0; k < 5; k++)
          data_op(1'b0, 32'h100 + word_t'(k * 4), '0, 1'b0);
      end
    join
    chk("starve_count", word_t'(order_q.size() - b0), 6);
    pat = '0;
    for (int k = 0; k < 6; k++)
      if (b0 + k < order_q.size()) pat[5 - k] = order_q[b0 + k];
    chk("starve_order", word_t'(pat), 32'b111101);
    step(2);

    // ERROR retry
    b0 = ren_cnt;
    b1 = dcomp;
    rs_q.push_back(ERROR);
    rs_q.push_back(ERROR);
    data_op(1'b0, 32'h104, '0, 1'b0);
    chk("err_ren_cycles", word_t'(ren_cnt - b0), 3);
    chk("err_completions", word_t'(dcomp - b1), 1);
    step(2);

    // Abort of a data read during BUSY
    rs_q.push_back(BUSY);
    rs_q.push_back(BUSY);
    iqa.push_back(32'h4c);
    iqd.push_back(rrd(32'h4c));
    iaddr = 32'h4c;
    iREN  = 1'b1;
    daddr = 32'h200;
    dREN  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("ab_grant", word_t'(ramREN), 1);
    chk("ab_grant_addr", ramaddr, 32'h200);
    @(posedge CLK);
    #1;
    dREN = 1'b0;
    @(negedge CLK);
    chk("ab_drop", word_t'(ramREN), 0);
    chk("ab_dwait", word_t'(dwait), 0);
    @(negedge CLK);
    chk("ab_idle", word_t'(ramREN), 0);
    @(negedge CLK);
    chk("ab_fetch_grant", word_t'(ramREN), 1);
    chk("ab_fetch_addr", ramaddr, 32'h4c);
    wait_done(1'b0);
    iREN = 1'b0;
    step(2);

    // Reset in the middle of a data write
    b1 = dcomp;
    rs_q.push_back(BUSY);
    rs_q.push_back(BUSY);
    rs_q.push_back(BUSY);
    fork
      data_op(1'b1, 32'h300, 32'h55, 1'b0);
      begin
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_mid_grant", word_t'(ramWEN), 1);
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_mid_wen", word_t'(ramWEN), 0);
        chk("rst_mid_ren", word_t'(ramREN), 0);
        chk("rst_mid_addr", ramaddr, 0);
        chk("rst_mid_dwait", word_t'(dwait), 1);
        @(negedge CLK);
        nRST = 1'b1;
      end
    join
    chk("rst_regrant", word_t'(dcomp - b1), 1);
    step(2);

    // Randomized concurrent traffic
    rnd = 1'b1;
    fork
      begin
        repeat (40) begin
          step($urandom_range(0, 3));
          fetch(32'h2000_0000 | word_t'($urandom_range(0, 255) << 2));
        end
      end
      begin
        repeat (60) begin
          step($urandom_range(0, 2));
          data_op(1'($urandom_range(0, 1)),
                  32'h1000_0000 | word_t'($urandom_range(0, 15) << 2),
                  word_t'($urandom), 1'($urandom_range(0, 1)));
        end
      end
    join
    step(3);
    chk("iq_drained", word_t'(iqa.size()), 0);
    chk("dq_drained", word_t'(dq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequential arbiter that shares the single RAM port between the instruction-fetch requester and the memory-stage data requester. Data requests come from the memory pipeline stage's load/store path. The block grants one requester at a time and holds the grant until the RAM reports completion. It gives data priority, bounded by a starvation counter so fetch always progresses. The requester wait outputs directly stall the fetch and memory stages.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending, before fetch is forced.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request, held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  high while the fetch is not yet complete.
- iload  out  32  instruction data, valid when iREN & !iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN & dWEN together is treated as a write.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  high while the data access is not yet complete.
- dload  out  32  read data, valid when dREN & !dwait.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE, BUSY, ACCESS or ERROR.

## Operation
- FSM states: IDLE, IGNT (fetch granted), DGNT (data granted). State resets to IDLE.
- IDLE decision, evaluated each cycle:
  - If a data request (dREN|dWEN) is present and fetch is not being forced, go to DGNT.
  - Else if iREN, go to IGNT.
  - Else stay in IDLE.
  - Fetch is forced when iREN & starve_cnt==STARVE_MAX.
- Grant capture: on entry to IGNT/DGNT, latch the request type (read/write), address and store data into grant registers. RAM outputs are driven only from these registers.
- IGNT/DGNT:
  - Drive ramREN, or ramWEN for a data write, every cycle.
  - ramstate ACCESS: completion; go to IDLE next cycle.
  - ramstate ERROR: keep the grant and re-issue the same access (no completion reported).
  - ramstate BUSY or FREE: hold.
- Abort: if the granted requester deasserts its request before ACCESS (pipeline flush), go to IDLE next cycle. No wait-low pulse is produced. Strobes drop in that same cycle (combinational gating).
- starve_cnt, 3 bits, saturating at STARVE_MAX:
  - Increments on each DGNT entry while iREN is high.
  - Clears on each IGNT entry, or when iREN is low in IDLE.
- Outputs:
  - iwait = iREN & !(state==IGNT & ramstate==ACCESS); dwait has the same form with DGNT.
  - iload and dload pass ramload through.
  - ramstore comes from the grant register.
- Reset values: state IDLE, starve_cnt 0, grant registers 0, ramREN/ramWEN 0, ramaddr 0, ramstore 0. iwait/dwait equal their request inputs, since no grant is held.
- Reset mid-transaction: strobes drop immediately (asynchronous) and the pending access is lost. Requesters see wait stay high until re-served.

## Timing
- The request is sampled in IDLE at edge N. The grant state and RAM strobes are valid from cycle N+1.
- Completion: wait goes low in the same cycle ramstate==ACCESS (combinational). The next arbitration happens in the following IDLE cycle.
- Minimum request-to-done latency is 1 cycle of RAM access plus the 1 IDLE cycle.
- Back-to-back requests from the same requester have at least one IDLE cycle between grants.
- Both requesters arriving in the same cycle: data wins unless fetch is forced.
- Writes are never merged or posted. Each write completes before dwait drops.

## Structure
- cpu_types_pkg holds:
  - ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t, both existing.
  - New arb_state_t (IDLE, IGNT, DGNT).
- One module only. The FSM plus grant registers total about 150 lines; no sub-module is warranted.

## Test plan
- Single fetch: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN high for 3 cycles, ramaddr=0x40; iwait low for 1 cycle with iload=0xDEADBEEF.
- Simultaneous requests: iREN and dWEN with daddr=0x100, dstore=0x1234 -> DGNT first, ramWEN=1, ramstore=0x1234; IGNT next; dwait drops before iwait.
- Starvation: iREN held while 5 back-to-back data reads are issued, STARVE_MAX=4 -> after the 4th data completion, IGNT is granted ahead of the 5th data read.
- ERROR retry: data read with ramstate=ERROR for 2 cycles, then ACCESS -> ramREN stays high throughout, dwait stays high until ACCESS, and exactly one completion is reported.
- Abort: dREN drops during BUSY -> strobes low the same cycle, state IDLE next cycle, pending iREN granted after that.
- Reset: nRST asserted mid-DGNT -> ramREN/ramWEN go to 0 immediately, state IDLE, starve_cnt 0; after nRST deasserts, the held request is re-granted.
